// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM state type and a 4 KiB crossing helper
// used by the burst master.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    // True when a burst starting at this page offset runs past the 4 KiB page
    function automatic logic crosses_4k(
        input logic [11:0] offs,
        input logic [7:0]  len,
        input int unsigned bytes
    );
        logic [19:0] span;
        span = 20'(offs) + (20'(len) + 20'd1) * 20'(bytes);
        return span > 20'd4096;
    endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the W and R phases: loads on command accept,
// advances per handshake, flags the final beat of the burst.
module axi_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       beat_i,
    input  logic [7:0] len_i,
    output logic       last_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (beat_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator with streaming data ports.
// Define AXI_BURST_MASTER_4K_CHECK_EN to reject bursts crossing 4 KiB.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int G_DATAWIDTH = 32,
    parameter int G_ADDRWIDTH = 32,
    parameter int G_ID_WIDTH  = 4,
    parameter int G_ID        = 0,
    parameter int G_WEWIDTH   = G_DATAWIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [G_ADDRWIDTH-1:0] cmd_addr,
    input  logic [7:0]             cmd_len,
    input  logic [G_DATAWIDTH-1:0] wr_data,
    input  logic [G_WEWIDTH-1:0]   wr_strb,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [G_DATAWIDTH-1:0] rd_data,
    output logic                   rd_last,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   done,
    output logic                   err,
    output logic [G_ID_WIDTH-1:0]  m_axi_awid,
    output logic [G_ADDRWIDTH-1:0] m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awlock,
    output logic [3:0]             m_axi_awcache,
    output logic [2:0]             m_axi_awprot,
    output logic [3:0]             m_axi_awqos,
    output logic [3:0]             m_axi_awregion,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [G_DATAWIDTH-1:0] m_axi_wdata,
    output logic [G_WEWIDTH-1:0]   m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [G_ID_WIDTH-1:0]  m_axi_arid,
    output logic [G_ADDRWIDTH-1:0] m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arlock,
    output logic [3:0]             m_axi_arcache,
    output logic [2:0]             m_axi_arprot,
    output logic [3:0]             m_axi_arqos,
    output logic [3:0]             m_axi_arregion,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [G_ID_WIDTH-1:0]  m_axi_rid,
    input  logic [G_DATAWIDTH-1:0] m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);

    localparam logic [2:0] AXSIZE = 3'($clog2(G_WEWIDTH));

    state_e                   state_q, state_d;
    logic [G_ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic                     err_q, err_d;
    logic                     in_w, in_r, cmd_fire, w_fire, r_fire;
    logic                     beat_last;
    logic                     unused_ids;

    assign in_w     = (state_q == ST_W);
    assign in_r     = (state_q == ST_R);
    assign cmd_fire = cmd_valid & cmd_ready;
    assign w_fire   = in_w & wr_valid & m_axi_wready;
    assign r_fire   = in_r & m_axi_rvalid & rd_ready;

    axi_beat_counter u_beats (
        .clk    (clk),
        .rst    (rst),
        .load_i (cmd_fire),
        .beat_i (w_fire | r_fire),
        .len_i  (len_q),
        .last_o (beat_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    err_d   = 1'b0;
                    state_d = cmd_write ? ST_AW : ST_AR;
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
                    if (crosses_4k(cmd_addr[11:0], cmd_len, G_WEWIDTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_AW: if (m_axi_awready) state_d = ST_W;
            ST_AR: if (m_axi_arready) state_d = ST_R;
            ST_W:  if (w_fire && beat_last) state_d = ST_B;
            ST_B: begin
                if (m_axi_bvalid) begin
                    err_d   = (m_axi_bresp != RESP_OKAY);
                    state_d = ST_DONE;
                end
            end
            ST_R: begin
                // rlast disagreeing with the beat count is a slave protocol error
                if (r_fire) begin
                    err_d = err_q | (m_axi_rresp != RESP_OKAY)
                          | (m_axi_rlast != beat_last);
                    if (m_axi_rlast || beat_last) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) & ~rst;
    assign done      = (state_q == ST_DONE);
    assign err       = done & err_q;

    assign m_axi_awid     = G_ID_WIDTH'(G_ID);
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = len_q;
    assign m_axi_awsize   = AXSIZE;
    assign m_axi_awburst  = BURST_INCR;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = CACHE_DEFAULT;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awqos    = 4'h0;
    assign m_axi_awregion = 4'h0;
    assign m_axi_awvalid  = (state_q == ST_AW);

    assign m_axi_wdata  = in_w ? wr_data : '0;
    assign m_axi_wstrb  = in_w ? wr_strb : '0;
    assign m_axi_wlast  = in_w & beat_last;
    assign m_axi_wvalid = in_w & wr_valid;
    assign wr_ready     = in_w & m_axi_wready;
    assign m_axi_bready = (state_q == ST_B);

    assign m_axi_arid     = G_ID_WIDTH'(G_ID);
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = len_q;
    assign m_axi_arsize   = AXSIZE;
    assign m_axi_arburst  = BURST_INCR;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = CACHE_DEFAULT;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arqos    = 4'h0;
    assign m_axi_arregion = 4'h0;
    assign m_axi_arvalid  = (state_q == ST_AR);

    assign rd_data      = in_r ? m_axi_rdata : '0;
    assign rd_last      = in_r & (m_axi_rlast | beat_last);
    assign rd_valid     = in_r & m_axi_rvalid;
    assign m_axi_rready = in_r & rd_ready;

    // Only one transaction is ever in flight, so returned IDs carry no information
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

endmodule
